// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the TX FSM state enum, baud divisor rounding and data width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data,
// full, empty, count (entries held, 0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Equal indices: the wrap bit tells full from empty.
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        pop_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 LSB first (8E1 with parity).
// Ports: clk, rst (sync, active-high), wr_valid/wr_data/wr_ready write
// port, tx serial line (idle high), tx_busy, fifo_count (queued bytes,
// excluding the byte being shifted).
// Option: define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 42_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic [7:0]     fifo_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           bit_end;
`ifdef UART_TX_PARITY_EN
  logic           par;
`endif

  // Ready depends on the count alone, so a full FIFO never takes a
  // byte even if a pop happens on the same edge.
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign bit_end  = baud_cnt == DIV_LAST;

  // Pop when idle, or at the last stop-bit cycle so the next start bit
  // follows with no gap.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP && bit_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // tx is driven from the current state, so the line trails the FSM by
  // one cycle; popped data lands in fifo_data one edge after the pop and
  // is copied into the shift register on the first START cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_ONE;
      end
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state   <= START;
            tx_busy <= 1'b1;
          end else begin
            tx_busy <= 1'b0;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_cnt == '0) begin
            shreg <= fifo_data;
`ifdef UART_TX_PARITY_EN
            par   <= ^fifo_data;
`endif
          end
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par;
          if (bit_end) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (!fifo_empty) begin
              state <= START;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
